max_unpool_grad_stream: RTL and testbench

- Streaming backward-pass block for the max-pool layer.
- Holds the per-window argmax offsets captured during the forward pass.
- Accepts pooled-map gradients in raster order over a valid/ready stream.
- Emits the expanded input-map gradient in raster order: the gradient goes to the argmax position of each window and every other position gets 0. Sits between layer X+1 backprop output and layer X-1 gradient input.

---
 rtl/max_pool_pkg.sv | 14 +
 rtl/max_pool_idx_ram.sv | 29 ++
 rtl/max_unpool_grad_stream.sv | 149 ++++++++++++++
 tb/tb_max_unpool_grad_stream.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/max_pool_pkg.sv
// Shared types for the max-pool layer pair: FSM state, gradient word, sizing helper.
package max_pool_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  localparam int GRAD_W = 16;
  typedef logic signed [GRAD_W-1:0] grad_t;

  // $clog2 that never returns 0, so single-entry counters still get a bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/max_pool_idx_ram.sv
// Argmax offset store: one window offset per pooled position, cleared on reset.
// Single write port, combinational read port.
module max_pool_idx_ram #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int IDXW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [IDXW-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [IDXW-1:0] rdata
);

  logic [IDXW-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && 32'(waddr) < DEPTH) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/max_unpool_grad_stream.sv
// Max-pool backward pass: buffers one pooled row of gradients, then expands it to
// STRIDE input rows routing each gradient to its argmax. Optional: MAX_UNPOOL_PROTO_CHK_EN.
module max_unpool_grad_stream
  import max_pool_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STRIDE = 2,
  parameter int IN_W   = 32,
  parameter int IN_H   = 32,
  parameter int OUT_W  = IN_W / STRIDE,
  parameter int OUT_H  = IN_H / STRIDE,
  parameter int IDXW   = clog2_min1(STRIDE * STRIDE),
  parameter int AW     = clog2_min1(OUT_W * OUT_H)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    idx_we,
  input  logic [AW-1:0]           idx_addr,
  input  logic [IDXW-1:0]         idx_data,
  input  logic                    g_in_valid,
  output logic                    g_in_ready,
  input  logic signed [WIDTH-1:0] g_in_data,
  input  logic                    g_in_last,
  output logic                    g_out_valid,
  input  logic                    g_out_ready,
  output logic signed [WIDTH-1:0] g_out_data,
  output logic                    g_out_last,
  output logic                    busy
`ifdef MAX_UNPOOL_PROTO_CHK_EN
  ,output logic                   proto_err
`endif
);

  localparam int CLW = clog2_min1(OUT_W);
  localparam int PRW = clog2_min1(OUT_H);
  localparam int SRW = clog2_min1(STRIDE);
  localparam int CW  = clog2_min1(IN_W);

  state_t                  state;
  logic [CLW-1:0]          col;
  logic [PRW-1:0]          prow;
  logic [SRW-1:0]          sr;
  logic [CW-1:0]           c;
  logic signed [WIDTH-1:0] gbuf [OUT_W];
  logic [IDXW-1:0]         ibuf [OUT_W];

  logic [AW-1:0]   rd_addr;
  logic [IDXW-1:0] rd_idx;
  logic [CLW-1:0]  slot;
  logic [31:0]     off;
  logic            in_fire, out_fire, row_full, last_prow;

  assign in_fire   = g_in_valid & g_in_ready;
  assign out_fire  = g_out_valid & g_out_ready;
  assign row_full  = (32'(col) == OUT_W - 1);
  assign last_prow = (prow == PRW'(OUT_H - 1));
  assign rd_addr   = AW'(32'(prow) * OUT_W + 32'(col));

  max_pool_idx_ram #(.DEPTH(OUT_W * OUT_H), .AW(AW), .IDXW(IDXW)) u_idx_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (idx_we && state == IDLE),
    .waddr (idx_addr),
    .wdata (idx_data),
    .raddr (rd_addr),
    .rdata (rd_idx)
  );

  // Output word is decoded from registered row buffers and position counters.
  assign slot        = CLW'(32'(c) / STRIDE);
  assign off         = 32'(sr) * STRIDE + 32'(c) % STRIDE;
  assign g_out_data  = (g_out_valid && 32'(ibuf[slot]) == off) ? gbuf[slot] : '0;
  assign g_out_last  = g_out_valid && last_prow && sr == SRW'(STRIDE - 1) && c == CW'(IN_W - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      col         <= '0;
      prow        <= '0;
      sr          <= '0;
      c           <= '0;
      g_in_ready  <= 1'b1;
      g_out_valid <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < OUT_W; i++) begin
        gbuf[i] <= '0;
        ibuf[i] <= '0;
      end
    end else begin
      case (state)
        // IDLE shares the load path: col and prow are already 0 there.
        IDLE, LOAD: begin
          if (in_fire) begin
            gbuf[col] <= g_in_data;
            ibuf[col] <= rd_idx;
            busy      <= 1'b1;
            if (row_full) begin
              col         <= '0;
              sr          <= '0;
              c           <= '0;
              state       <= EMIT;
              g_in_ready  <= 1'b0;
              g_out_valid <= 1'b1;
            end else begin
              col   <= col + 1'b1;
              state <= LOAD;
            end
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (c == CW'(IN_W - 1)) begin
              c <= '0;
              if (sr == SRW'(STRIDE - 1)) begin
                sr          <= '0;
                g_in_ready  <= 1'b1;
                g_out_valid <= 1'b0;
                if (last_prow) begin
                  prow  <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
                end else begin
                  prow  <= prow + 1'b1;
                  state <= LOAD;
                end
              end else begin
                sr <= sr + 1'b1;
              end
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAX_UNPOOL_PROTO_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) proto_err <= 1'b0;
    else if (in_fire && (g_in_last != (row_full && last_prow))) proto_err <= 1'b1;
  end
`else
  logic unused_last;
  assign unused_last = g_in_last;
`endif

endmodule

// File: tb/tb_max_unpool_grad_stream.sv
// Randomized frames on a 4x4 map checked against a window/argmax reference model.
module tb_max_unpool_grad_stream;

  logic               clk = 1'b0;
  logic               rst;
  logic               idx_we;
  logic [1:0]         idx_addr;
  logic [1:0]         idx_data;
  logic               g_in_valid;
  logic               g_in_ready;
  logic signed [15:0] g_in_data;
  logic               g_in_last;
  logic               g_out_valid;
  logic               g_out_ready;
  logic signed [15:0] g_out_data;
  logic               g_out_last;
  logic               busy;
`ifdef MAX_UNPOOL_PROTO_CHK_EN
  logic               proto_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int m_idx [4];
  int g_arr [4];

  always #5 clk = ~clk;

  max_unpool_grad_stream #(.WIDTH(16), .STRIDE(2), .IN_W(4), .IN_H(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .idx_we      (idx_we),
    .idx_addr    (idx_addr),
    .idx_data    (idx_data),
    .g_in_valid  (g_in_valid),
    .g_in_ready  (g_in_ready),
    .g_in_data   (g_in_data),
    .g_in_last   (g_in_last),
    .g_out_valid (g_out_valid),
    .g_out_ready (g_out_ready),
    .g_out_data  (g_out_data),
    .g_out_last  (g_out_last),
    .busy        (busy)
`ifdef MAX_UNPOOL_PROTO_CHK_EN
    ,.proto_err  (proto_err)
`endif
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic write_idx(input int a, input int d);
    @(negedge clk);
    idx_we   = 1'b1;
    idx_addr = 2'(a);
    idx_data = 2'(d);
    @(negedge clk);
    idx_we   = 1'b0;
    m_idx[a] = d;
  endtask

  task automatic write_all(input int d0, input int d1, input int d2, input int d3);
    write_idx(0, d0);
    write_idx(1, d1);
    write_idx(2, d2);
    write_idx(3, d3);
  endtask

  // Streams g_arr as one frame and checks every expanded beat against the model.
  task automatic run_frame(input bit rnd_rdy, input bit rnd_vld, input bit busy_wr,
                           input logic [3:0] lastm);
    int  expq [$];
    int  sent = 0, got = 0, cyc = 0;
    bit  vld_next = 1'b0, wr_done = 1'b0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        int p, o;
        p = (y / 2) * 2 + x / 2;
        o = (y % 2) * 2 + x % 2;
        expq.push_back((m_idx[p] == o) ? g_arr[p] : 0);
      end
    while (got < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      g_in_valid  = (sent < 4) && (!rnd_vld || $urandom_range(0, 3) != 0);
      g_in_data   = (sent < 4) ? 16'(g_arr[sent]) : 16'sd0;
      g_in_last   = (sent < 4) ? lastm[sent] : 1'b0;
      g_out_ready = !rnd_rdy || ($urandom_range(0, 1) == 1);
      idx_we      = busy_wr && !wr_done && busy;
      idx_addr    = 2'd0;
      idx_data    = 2'd2;
      if (idx_we) wr_done = 1'b1;
      #1;
      if (vld_next) chk("first_valid_latency", int'(g_out_valid), 1);
      vld_next = 1'b0;
      if (g_out_valid) begin
        chk("in_ready_low_in_emit", int'(g_in_ready), 0);
        chk($sformatf("data_beat%0d", got), int'(g_out_data), expq[0]);
        if (g_out_ready) begin
          chk($sformatf("last_beat%0d", got), int'(g_out_last), (got == 15) ? 1 : 0);
          void'(expq.pop_front());
          got++;
        end
      end
      if (g_in_valid && g_in_ready) begin
        sent++;
        if (sent % 2 == 0) vld_next = 1'b1;
      end
    end
    chk("frame_beats", got, 16);
    @(negedge clk);
    idx_we      = 1'b0;
    g_in_valid  = 1'b0;
    g_in_last   = 1'b0;
    g_out_ready = 1'b0;
    #1;
    chk("idle_busy", int'(busy), 0);
    chk("idle_in_ready", int'(g_in_ready), 1);
  endtask

  task automatic set_grads(input int a, input int b, input int c, input int d);
    g_arr[0] = a; g_arr[1] = b; g_arr[2] = c; g_arr[3] = d;
  endtask

  initial begin
    rst = 1'b1; idx_we = 1'b0; idx_addr = '0; idx_data = '0;
    g_in_valid = 1'b0; g_in_data = '0; g_in_last = 1'b0; g_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) m_idx[i] = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", int'(g_in_ready), 1);
    chk("rst_out_valid", int'(g_out_valid), 0);
    chk("rst_out_data", int'(g_out_data), 0);
    chk("rst_out_last", int'(g_out_last), 0);
    chk("rst_busy", int'(busy), 0);
`ifdef MAX_UNPOOL_PROTO_CHK_EN
    chk("rst_proto_err", int'(proto_err), 0);
`endif
    rst = 1'b0;

    set_grads(1, 2, 3, 4);
    run_frame(1'b0, 1'b0, 1'b0, 4'b1000);

    write_all(3, 3, 3, 3);
    set_grads(-5, 6, -7, 8);
    run_frame(1'b0, 1'b0, 1'b0, 4'b1000);

    write_all(1, 2, 0, 3);
    set_grads(9, 9, 9, 9);
    run_frame(1'b1, 1'b0, 1'b0, 4'b1000);

    // Write while busy is dropped; the same write in IDLE lands.
    write_all(0, 0, 0, 0);
    set_grads(1, 2, 3, 4);
    run_frame(1'b0, 1'b0, 1'b1, 4'b1000);
    write_idx(0, 2);
    run_frame(1'b1, 1'b0, 1'b0, 4'b1000);

    // Reset during EMIT of row 0.
    write_all(3, 3, 3, 3);
    begin
      int k = 0, cyc = 0;
      g_out_ready = 1'b0;
      while (!g_out_valid && cyc < 50) begin
        @(negedge clk);
        cyc++;
        g_in_valid = (k < 2);
        g_in_data  = 16'sd7;
        g_in_last  = 1'b0;
        #1;
        if (g_in_valid && g_in_ready) k++;
      end
      chk("abort_reached_emit", int'(g_out_valid), 1);
      @(negedge clk);
      g_in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("abort_out_valid", int'(g_out_valid), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_in_ready", int'(g_in_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m_idx[i] = 0;
    end
    set_grads(1, 2, 3, 4);
    run_frame(1'b0, 1'b0, 1'b0, 4'b1000);

    for (int f = 0; f < 4; f++) begin
      write_all($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      set_grads($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
      run_frame(1'b1, 1'b1, 1'b0, 4'b1000);
    end

`ifdef MAX_UNPOOL_PROTO_CHK_EN
    chk("proto_clean", int'(proto_err), 0);
    set_grads(1, 2, 3, 4);
    run_frame(1'b0, 1'b0, 1'b0, 4'b0010);
    chk("proto_set", int'(proto_err), 1);
    @(negedge clk);
    #1;
    chk("proto_sticky", int'(proto_err), 1);
    rst = 1'b1;
    #1;
    chk("proto_rst_clear", int'(proto_err), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_idx[i] = 0;
    run_frame(1'b0, 1'b0, 1'b0, 4'b1000);
    chk("proto_correct_last", int'(proto_err), 0);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
